hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_div_ctrl.sv | 130 +++++++++++++
 tb/tb_hilo_div_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl -- HI/LO register file plus sequencing for an external
// multi-cycle divider.
//
// MULT/MULTU/MTHI/MTLO retire in one cycle straight into HI/LO. DIV/DIVU
// launch the external divider, stall the front of the pipe until the
// divider reports completion, and then spend one DONE cycle with stall low.
// In that DONE cycle the divide instruction is still sitting in EX, so it
// must not be decoded a second time.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   op_valid, op               EX-stage HI/LO-class instruction and opcode
//   rs_data, rt_data           dividend / MTHI / MTLO source, divisor
//   prod                       combinational multiplier product
//   flush                      cancel the EX instruction (also aborts a divide)
//   stall                      hold EX and all earlier stages (combinational)
//   div_en, div_signed         divider enable and sign mode (registered)
//   div_dividend, div_divisor  divider operands (registered, stable in BUSY)
//   div_quotient, div_remainder, div_complete   divider results
//   hi, lo                     architectural HI/LO
module hilo_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               flush,
    output logic               stall,
    output logic               div_en,
    output logic               div_signed,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic [WIDTH-1:0]   div_quotient,
    input  logic [WIDTH-1:0]   div_remainder,
    input  logic               div_complete,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MULTU = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Everything the divider sees, held as one register so the operands
    // and sign mode obviously move together.
    typedef struct packed {
        logic             en;
        logic             sgn;
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
    } div_req_t;

    state_t   state;
    div_req_t div_req;
    logic     is_div;
    logic     div_start;

    assign is_div    = op_valid && ((op == OP_DIV) || (op == OP_DIVU));
    assign div_start = (state == IDLE) && is_div && !flush;

    // Stall from the request cycle onward; the BUSY term is deliberately
    // not gated by flush so a flushed divide still holds for that cycle.
    assign stall = div_start || (state == BUSY);

    assign div_en       = div_req.en;
    assign div_signed   = div_req.sgn;
    assign div_dividend = div_req.dividend;
    assign div_divisor  = div_req.divisor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            div_req <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid && !flush) begin
                        case (op)
                            OP_DIV, OP_DIVU: begin
                                div_req.en       <= 1'b1;
                                div_req.sgn      <= (op == OP_DIV);
                                div_req.dividend <= rs_data;
                                div_req.divisor  <= rt_data;
                                state            <= BUSY;
                            end
                            OP_MULT, OP_MULTU: {hi, lo} <= prod;
                            OP_MTHI:           hi <= rs_data;
                            OP_MTLO:           lo <= rs_data;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Flush beats completion: the result of a cancelled
                    // divide must never reach HI/LO.
                    if (flush) begin
                        div_req.en <= 1'b0;
                        state      <= IDLE;
                    end else if (div_complete) begin
                        lo         <= div_quotient;
                        hi         <= div_remainder;
                        div_req.en <= 1'b0;
                        state      <= DONE;
                    end
                end
                // The finished divide is still in EX here; skip decode so it
                // is not re-issued. This also guarantees div_en spends at
                // least one cycle low before the next divide.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
module tb_hilo_div_ctrl;
    localparam int W = 32;

    localparam logic [2:0] OP_DIV   = 3'd0;
    localparam logic [2:0] OP_DIVU  = 3'd1;
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MULTU = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_valid;
    logic [2:0]     op;
    logic [W-1:0]   rs_data, rt_data;
    logic [2*W-1:0] prod;
    logic           flush;
    logic           stall, div_en, div_signed;
    logic [W-1:0]   div_dividend, div_divisor;
    logic [W-1:0]   div_quotient, div_remainder;
    logic           div_complete;
    logic [W-1:0]   hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    // expected architectural HI/LO
    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .prod(prod), .flush(flush),
        .stall(stall), .div_en(div_en), .div_signed(div_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_complete(div_complete), .hi(hi), .lo(lo)
    );

    // Reference division: MIPS truncating semantics, no trap on /0.
    function automatic logic [2*W-1:0] ref_div(input logic sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic [W-1:0] min_neg;
        min_neg = {1'b1, {(W-1){1'b0}}};
        if (b == '0) begin
            q = '1; r = a;
        end else if (sgn) begin
            if (a == min_neg && b == '1) begin
                q = min_neg; r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b;
        end
        return {r, q};
    endfunction

    // Divider behaviour: completes in the (W+2)th consecutive cycle of div_en.
    int   div_cnt = 0;
    logic force_complete;
    always @(posedge clk) begin
        if (!reset || !div_en) div_cnt <= 0;
        else                   div_cnt <= div_cnt + 1;
    end
    assign {div_remainder, div_quotient} = ref_div(div_signed, div_dividend, div_divisor);
    assign div_complete = force_complete | (div_en && div_cnt == W + 1);

    // Advance while stall is high, bounded; cycles = number of stalled cycles.
    task automatic wait_stall_low(output int cycles);
        cycles = 0;
        while (stall === 1'b1 && cycles < 100) begin
            @(negedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd9; rt_data = 32'd3;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (hi !== '0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_checks++; if (lo !== '0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_checks++; if (div_en !== 1'b0) begin n_fail++; $display("FAIL reset_div_en got=%b exp=0", div_en); end
        n_checks++; if (div_signed !== 1'b0) begin n_fail++; $display("FAIL reset_div_signed got=%b exp=0", div_signed); end
        n_checks++; if (div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++; $display("FAIL reset_operands got=%h/%h exp=0/0", div_dividend, div_divisor); end
        op_valid = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (stall !== 1'b0 || div_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_release got stall=%b div_en=%b exp=0/0", stall, div_en); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk); op_valid = 1'b1; op = OP_MTHI; rs_data = 32'h1234; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got=%b exp=0", stall); end
        @(negedge clk); op = OP_MTLO; rs_data = 32'h5678; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall got=%b exp=0", stall); end
        n_checks++; if (hi !== 32'h1234 || lo !== m_lo) begin
            n_fail++; $display("FAIL mthi_write got=%h/%h exp=%h/%h", hi, lo, 32'h1234, m_lo); end
        @(negedge clk); op_valid = 1'b0; #1;
        n_checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            n_fail++; $display("FAIL mtlo_write got=%h/%h exp=1234/5678", hi, lo); end
        m_hi = 32'h1234; m_lo = 32'h5678;
    endtask

    task automatic test_mult;
        @(negedge clk); op_valid = 1'b1; op = OP_MULT; prod = 64'h00000002_FFFFFFFE; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_stall got=%b exp=0", stall); end
        @(negedge clk); op = OP_MULTU; prod = 64'hDEADBEEF_01234567; #1;
        n_checks++; if (hi !== 32'h2 || lo !== 32'hFFFFFFFE) begin
            n_fail++; $display("FAIL mult_write got=%h/%h exp=2/fffffffe", hi, lo); end
        @(negedge clk); op_valid = 1'b0; #1;
        n_checks++; if (hi !== 32'hDEADBEEF || lo !== 32'h01234567) begin
            n_fail++; $display("FAIL multu_write got=%h/%h exp=deadbeef/01234567", hi, lo); end
        m_hi = 32'hDEADBEEF; m_lo = 32'h01234567;
    endtask

    // Inputs that must leave HI/LO and the divider alone.
    task automatic test_noop;
        logic       v_t  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] op_t [6] = '{3'd6, 3'd7, OP_MTHI, OP_MTLO, OP_DIVU, OP_DIV};
        logic       fl_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            op_valid = v_t[i]; op = op_t[i]; flush = fl_t[i];
            rs_data = $urandom; rt_data = $urandom; prod = {$urandom, $urandom};
            #1;
            n_checks++; if (stall !== 1'b0 || div_en !== 1'b0) begin
                n_fail++; $display("FAIL noop_%0d got stall=%b div_en=%b exp=0/0", i, stall, div_en); end
        end
        @(negedge clk); op_valid = 1'b0; flush = 1'b0; #1;
        n_checks++; if (hi !== m_hi || lo !== m_lo || div_en !== 1'b0) begin
            n_fail++; $display("FAIL noop_hilo got=%h/%h en=%b exp=%h/%h en=0", hi, lo, div_en, m_hi, m_lo); end
    endtask

    task automatic test_divu_latency;
        @(negedge clk); op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; #1;
        n_checks++; if (stall !== 1'b1 || div_en !== 1'b0) begin
            n_fail++; $display("FAIL divu_c0 got stall=%b div_en=%b exp=1/0", stall, div_en); end
        for (int c = 1; c <= W + 2; c++) begin
            @(negedge clk); #1;
            n_checks++; if (stall !== 1'b1 || div_en !== 1'b1) begin
                n_fail++; $display("FAIL divu_busy_c%0d got stall=%b div_en=%b exp=1/1", c, stall, div_en); end
            n_checks++; if (div_dividend !== 32'd100 || div_divisor !== 32'd7 || div_signed !== 1'b0) begin
                n_fail++; $display("FAIL divu_operands_c%0d got=%0d/%0d s=%b exp=100/7 s=0",
                                   c, div_dividend, div_divisor, div_signed); end
        end
        n_checks++; if (hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL divu_early_write got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
        @(negedge clk); #1;
        n_checks++; if (stall !== 1'b0 || div_en !== 1'b0) begin
            n_fail++; $display("FAIL divu_done got stall=%b div_en=%b exp=0/0", stall, div_en); end
        n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin
            n_fail++; $display("FAIL divu_result got lo=%0d hi=%0d exp lo=14 hi=2", lo, hi); end
        @(negedge clk); op_valid = 1'b0; #1;
        m_hi = 32'd2; m_lo = 32'd14;
    endtask

    task automatic test_div_signed_hold;
        int cyc;
        @(negedge clk); op_valid = 1'b1; op = OP_DIV; rs_data = 32'hFFFFFFF9; rt_data = 32'd2; #1;
        wait_stall_low(cyc);
        n_checks++; if (cyc != W + 3) begin n_fail++; $display("FAIL div_stall_cycles got=%0d exp=%0d", cyc, W + 3); end
        n_checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL div_signed_result got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        n_checks++; if (div_signed !== 1'b1) begin n_fail++; $display("FAIL div_signed_mode got=%b exp=1", div_signed); end
        // op_valid was held through DONE: a re-issue would show up now
        @(negedge clk); op_valid = 1'b0; #1;
        n_checks++; if (div_en !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL div_no_reissue got div_en=%b stall=%b exp=0/0", div_en, stall); end
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
    endtask

    task automatic test_flush_busy;
        int cyc;
        @(negedge clk); op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd50; rt_data = 32'd5; #1;
        repeat (10) @(negedge clk);
        flush = 1'b1; #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_c10_stall got=%b exp=1", stall); end
        @(negedge clk); flush = 1'b0; op_valid = 1'b0; #1;
        n_checks++; if (div_en !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_c11 got div_en=%b stall=%b exp=0/0", div_en, stall); end
        n_checks++; if (hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL flush_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
        @(negedge clk); op_valid = 1'b1; op = OP_DIVU; rs_data = 32'd9; rt_data = 32'd4; #1;
        wait_stall_low(cyc);
        n_checks++; if (cyc != W + 3) begin n_fail++; $display("FAIL flush_redo_cycles got=%0d exp=%0d", cyc, W + 3); end
        n_checks++; if (lo !== 32'd2 || hi !== 32'd1) begin
            n_fail++; $display("FAIL flush_redo_result got lo=%0d hi=%0d exp lo=2 hi=1", lo, hi); end
        @(negedge clk); op_valid = 1'b0; #1;
        m_hi = 32'd1; m_lo = 32'd2;
    endtask

    task automatic test_flush_on_complete;
        int cyc;
        @(negedge clk); op_valid = 1'b1; op = OP_DIVU; rs_data = 32'hFF; rt_data = 32'h10; #1;
        repeat (W + 2) @(negedge clk);
        flush = 1'b1; #1;
        n_checks++; if (div_complete !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL foc_c34 got complete=%b stall=%b exp=1/1", div_complete, stall); end
        // back in IDLE: a new divide presented now must be accepted at once
        @(negedge clk); flush = 1'b0; op = OP_DIVU; rs_data = 32'd20; rt_data = 32'd3; #1;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL foc_idle_accept got stall=%b exp=1", stall); end
        n_checks++; if (hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL foc_hilo got=%h/%h exp=%h/%h", hi, lo, m_hi, m_lo); end
        wait_stall_low(cyc);
        n_checks++; if (cyc != W + 3) begin n_fail++; $display("FAIL foc_redo_cycles got=%0d exp=%0d", cyc, W + 3); end
        n_checks++; if (lo !== 32'd6 || hi !== 32'd2) begin
            n_fail++; $display("FAIL foc_redo_result got lo=%0d hi=%0d exp lo=6 hi=2", lo, hi); end
        @(negedge clk); op_valid = 1'b0; #1;
        m_hi = 32'd2; m_lo = 32'd6;
    endtask

    task automatic test_complete_outside_busy;
        @(negedge clk); op_valid = 1'b1; op = OP_MTHI; rs_data = 32'hAAAA;
        @(negedge clk); op = OP_MTLO; rs_data = 32'h5555;
        @(negedge clk); op_valid = 1'b0; force_complete = 1'b1; #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stray_complete_stall got=%b exp=0", stall); end
        @(negedge clk); #1;
        n_checks++; if (hi !== 32'hAAAA || lo !== 32'h5555 || div_en !== 1'b0) begin
            n_fail++; $display("FAIL stray_complete got=%h/%h en=%b exp=aaaa/5555 en=0", hi, lo, div_en); end
        @(negedge clk); force_complete = 1'b0; #1;
        n_checks++; if (hi !== 32'hAAAA || lo !== 32'h5555 || stall !== 1'b0) begin
            n_fail++; $display("FAIL stray_complete_after got=%h/%h stall=%b exp=aaaa/5555 0", hi, lo, stall); end
        m_hi = 32'hAAAA; m_lo = 32'h5555;
    endtask

    task automatic test_reset_mid_div;
        int cyc;
        @(negedge clk); op_valid = 1'b1; op = OP_DIV; rs_data = 32'h12345678; rt_data = 32'd9; #1;
        repeat (20) @(negedge clk);
        reset = 1'b0; op_valid = 1'b0; #1;
        @(negedge clk); reset = 1'b1; #1;
        n_checks++; if (stall !== 1'b0 || div_en !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid got stall=%b div_en=%b exp=0/0", stall, div_en); end
        n_checks++; if (hi !== '0 || lo !== '0) begin
            n_fail++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", hi, lo); end
        n_checks++; if (div_dividend !== '0 || div_divisor !== '0 || div_signed !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_operands got=%h/%h s=%b exp=0/0 s=0", div_dividend, div_divisor, div_signed); end
        @(negedge clk); op_valid = 1'b1; op = OP_MTHI; rs_data = 32'h77; #1;
        @(negedge clk); op = OP_DIVU; rs_data = 32'h10; rt_data = 32'h0; #1;
        n_checks++; if (hi !== 32'h77 || stall !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_idle got hi=%h stall=%b exp=77/1", hi, stall); end
        wait_stall_low(cyc);
        n_checks++; if (cyc != W + 3) begin n_fail++; $display("FAIL divz_cycles got=%0d exp=%0d", cyc, W + 3); end
        n_checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h10) begin
            n_fail++; $display("FAIL divz_result got=%h/%h exp=10/ffffffff", hi, lo); end
        @(negedge clk); op_valid = 1'b0; #1;
        m_hi = 32'h10; m_lo = 32'hFFFFFFFF;
    endtask

    task automatic test_random;
        int           cyc, exp_cyc;
        logic         v, fl;
        logic [2:0]   o;
        logic [W-1:0] a, b;
        logic [2*W-1:0] p, qr;
        for (int i = 0; i < 60; i++) begin
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            o  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = '1; end
            p  = {$urandom, $urandom};
            exp_cyc = 0;
            if (v && !fl) begin
                case (o)
                    OP_DIV, OP_DIVU: begin
                        qr = ref_div(o == OP_DIV, a, b);
                        m_hi = qr[2*W-1:W]; m_lo = qr[W-1:0]; exp_cyc = W + 3;
                    end
                    OP_MULT, OP_MULTU: {m_hi, m_lo} = p;
                    OP_MTHI: m_hi = a;
                    OP_MTLO: m_lo = a;
                    default: ;
                endcase
            end
            @(negedge clk);
            op_valid = v; flush = fl; op = o; rs_data = a; rt_data = b; prod = p;
            #1;
            wait_stall_low(cyc);
            n_checks++; if (cyc != exp_cyc) begin
                n_fail++; $display("FAIL rand%0d_stall op=%0d v=%b fl=%b got=%0d exp=%0d", i, o, v, fl, cyc, exp_cyc); end
            @(negedge clk); op_valid = 1'b0; flush = 1'b0; #1;
            n_checks++; if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL rand%0d_hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h",
                                   i, o, a, b, hi, lo, m_hi, m_lo); end
            n_checks++; if (div_en !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_div_en got=%b exp=0", i, div_en); end
        end
    endtask

    initial begin
        reset = 1'b0; op_valid = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        prod = '0; flush = 1'b0; force_complete = 1'b0;
        m_hi = '0; m_lo = '0;
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_noop();
        test_divu_latency();
        test_div_signed_hold();
        test_flush_busy();
        test_flush_on_complete();
        test_complete_outside_busy();
        test_reset_mid_div();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
